// File: rtl/mem_arb_pkg.sv
// Shared opcodes, state encoding and grant encoding for the RAM arbiter.
// Used by rr_arb2 and mem_arbiter; the macro MEMARB_LOADER_PRIORITY_EN is consumed in rr_arb2.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDDATA = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: req[0] is the CPU, req[1] the loader; gnt uses GNT_CPU/GNT_LD.
// MEMARB_LOADER_PRIORITY_EN selects fixed loader priority instead of round-robin on a tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic       gnt
);

`ifdef MEMARB_LOADER_PRIORITY_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    gnt = GNT_CPU;
    if (en) begin
      case (req)
        2'b01:   gnt = GNT_CPU;
        2'b10:   gnt = GNT_LD;
`ifdef MEMARB_LOADER_PRIORITY_EN
        2'b11:   gnt = GNT_LD;
`else
        2'b11:   gnt = ~last_gnt;
`endif
        default: gnt = GNT_CPU;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto one single-port synchronous-read RAM.
// Tie-break mode is chosen in rr_arb2 by MEMARB_LOADER_PRIORITY_EN (default: round-robin).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises its request (cmd 01/10, or ld_req) and holds it with
  // stable operands until its single-cycle ready/done pulse; rdata is valid during that pulse.
  state_t            state;
  logic              gnt_q;
  logic              last_gnt;
  logic              op_we;
  logic              win;
  logic              cpu_pend;
  logic              ld_pend;
  logic              done_wr;
  logic              done_rd;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;

  assign cpu_pend = (cpu_mem_cmd == MREAD) || (cpu_mem_cmd == MWRITE);
  assign ld_pend  = ld_req;

  rr_arb2 u_arb (
    .req      ({ld_pend, cpu_pend}),
    .last_gnt (last_gnt),
    .en       (state == S_IDLE),
    .gnt      (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      gnt_q       <= GNT_CPU;
      last_gnt    <= GNT_LD;
      op_we       <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_pend || ld_pend) begin
            gnt_q    <= win;
            last_gnt <= win;
            state    <= S_ACCESS;
            if (win == GNT_LD) begin
              ram_addr <= ld_addr;
              ram_din  <= ld_wdata;
              op_we    <= ld_we;
            end else begin
              ram_addr <= cpu_mem_addr;
              ram_din  <= cpu_wdata;
              op_we    <= (cpu_mem_cmd == MWRITE);
            end
          end
        end
        S_ACCESS: state <= op_we ? S_IDLE : S_RDDATA;
        S_RDDATA: begin
          state <= S_IDLE;
          if (gnt_q == GNT_CPU) cpu_rdata_q <= ram_dout;
          else                  ld_rdata_q  <= ram_dout;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion decode is gated by reset so a transaction cut short by reset never reports done.
  assign done_wr   = (state == S_ACCESS) && op_we && !reset;
  assign done_rd   = (state == S_RDDATA) && !reset;
  assign ram_write = done_wr;
  assign cpu_ready = (done_wr || done_rd) && (gnt_q == GNT_CPU);
  assign ld_done   = (done_wr || done_rd) && (gnt_q == GNT_LD);
  assign cpu_rdata = (done_rd && gnt_q == GNT_CPU) ? ram_dout : cpu_rdata_q;
  assign ld_rdata  = (done_rd && gnt_q == GNT_LD)  ? ram_dout : ld_rdata_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
